bottle_capper: RTL

- Capping station directly downstream of the bottle filling stage.
- Consumes the filler's "bottle released" pulse and tracks bottles in transit between the two stations.
- For each bottle: indexes it into the capping head, places a cap, spins it to torque, then releases it.
- Bottles that fail torque are rejected. Faults latch an alarm until an operator clears them.

---
 rtl/bottle_capper.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bottle_capper.sv
// Capping station: tracks bottles in transit from the filler, then indexes, caps, torques and releases/rejects each.
// Optional CAPPER_STATS_EN adds reject_count and last_torque_cycles outputs.
module bottle_capper #(
  parameter int unsigned INDEX_TIMEOUT  = 50,
  parameter int unsigned PLACE_CYCLES   = 3,
  parameter int unsigned TORQUE_TIMEOUT = 20,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter int unsigned MAX_INFLIGHT   = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_done,
  input  logic             cap_sensor,
  input  logic             cap_empty,
  input  logic             torque_ok,
  input  logic             estop,
  input  logic             fault_clr,
  output logic             conveyor_on,
  output logic             press_down,
  output logic             spin_on,
  output logic             reject,
  output logic             alarm,
  output logic [1:0]       fault_code,
  output logic [2:0]       inflight,
`ifdef CAPPER_STATS_EN
  output logic [CNT_W-1:0] reject_count,
  output logic [4:0]       last_torque_cycles,
`endif
  output logic [CNT_W-1:0] good_count
);

  localparam int unsigned INFL_W    = 3;
  localparam int unsigned TMR_MAX_A = (INDEX_TIMEOUT > TORQUE_TIMEOUT) ? INDEX_TIMEOUT : TORQUE_TIMEOUT;
  localparam int unsigned TMR_MAX_B = (PLACE_CYCLES > RELEASE_CYCLES) ? PLACE_CYCLES : RELEASE_CYCLES;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
  localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]  INDEX_LAST   = TMR_W'(INDEX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  PLACE_LAST   = TMR_W'(PLACE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TORQUE_LAST  = TMR_W'(TORQUE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  RELEASE_LAST = TMR_W'(RELEASE_CYCLES - 1);
  localparam logic [INFL_W-1:0] INFL_FULL    = INFL_W'(MAX_INFLIGHT);

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_ESTOP  = 2'd1;
  localparam logic [1:0] FC_INDEX  = 2'd2;
  localparam logic [1:0] FC_HOPPER = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INDEX,
    S_PLACE,
    S_TORQUE,
    S_RELEASE,
    S_REJECT,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         code_q, code_d;
  logic [INFL_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]   good_q, good_d;
  logic               conveyor_q, conveyor_d;
  logic               press_q, press_d;
  logic               spin_q, spin_d;
  logic               reject_q, reject_d;
  logic               alarm_q, alarm_d;
  logic               to_place;
  logic               overflow;

  // Next state, fault cause and in-transit bookkeeping
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    inflight_d = inflight_q;
    to_place   = 1'b0;
    overflow   = 1'b0;

    if (state_q == S_FAULT) begin
      if (estop) begin
        code_d = FC_ESTOP;
      end else if (fault_clr) begin
        state_d    = S_IDLE;
        code_d     = FC_NONE;
        inflight_d = '0;
      end
    end else begin
      to_place = (state_q == S_INDEX) && cap_sensor && !estop;

      if (fill_done && !to_place) begin
        if (inflight_q == INFL_FULL) begin
          overflow = 1'b1;
        end else begin
          inflight_d = inflight_q + INFL_W'(1);
        end
      end else if (!fill_done && to_place) begin
        inflight_d = inflight_q - INFL_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (inflight_q != '0) state_d = S_INDEX;
        end
        S_INDEX: begin
          if (cap_sensor) begin
            state_d = S_PLACE;
          end else if (timer_q == INDEX_LAST) begin
            state_d = S_FAULT;
            code_d  = FC_INDEX;
          end
        end
        S_PLACE: begin
          if (cap_empty) begin
            state_d = S_FAULT;
            code_d  = FC_HOPPER;
          end else if (timer_q == PLACE_LAST) begin
            state_d = S_TORQUE;
          end
        end
        S_TORQUE: begin
          if (torque_ok) begin
            state_d = S_RELEASE;
          end else if (timer_q == TORQUE_LAST) begin
            state_d = S_REJECT;
          end
        end
        S_RELEASE: begin
          if (timer_q == RELEASE_LAST) state_d = S_IDLE;
        end
        S_REJECT: begin
          if (timer_q == RELEASE_LAST) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // Emergency stop outranks overflow, which outranks the state-local moves
      if (estop) begin
        state_d = S_FAULT;
        code_d  = FC_ESTOP;
      end else if (overflow) begin
        state_d = S_FAULT;
        code_d  = FC_INDEX;
      end
    end
  end

  // State timer and good-bottle counter
  always_comb begin
    timer_d = (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
    good_d  = good_q;
    if (state_q == S_RELEASE && state_d == S_IDLE) good_d = good_q + CNT_W'(1);
  end

  // Moore outputs decoded from the next state so they line up with state_q
  always_comb begin
    conveyor_d = 1'b0;
    press_d    = 1'b0;
    spin_d     = 1'b0;
    reject_d   = 1'b0;
    alarm_d    = 1'b0;
    case (state_d)
      S_INDEX, S_RELEASE: conveyor_d = 1'b1;
      S_PLACE:            press_d    = 1'b1;
      S_TORQUE: begin
        press_d = 1'b1;
        spin_d  = 1'b1;
      end
      S_REJECT: begin
        reject_d   = 1'b1;
        conveyor_d = 1'b1;
      end
      S_FAULT:            alarm_d    = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      code_q     <= FC_NONE;
      inflight_q <= '0;
      good_q     <= '0;
      conveyor_q <= 1'b0;
      press_q    <= 1'b0;
      spin_q     <= 1'b0;
      reject_q   <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      inflight_q <= inflight_d;
      good_q     <= good_d;
      conveyor_q <= conveyor_d;
      press_q    <= press_d;
      spin_q     <= spin_d;
      reject_q   <= reject_d;
      alarm_q    <= alarm_d;
    end
  end

  assign conveyor_on = conveyor_q;
  assign press_down  = press_q;
  assign spin_on     = spin_q;
  assign reject      = reject_q;
  assign alarm       = alarm_q;
  assign fault_code  = code_q;
  assign inflight    = inflight_q;
  assign good_count  = good_q;

`ifdef CAPPER_STATS_EN
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic [4:0]       last_tq_q, last_tq_d;
  logic [TMR_W:0]   tq_cycles;

  // Reject tally and saturating spin time of the bottle leaving TORQUE
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    last_tq_d = last_tq_q;
    tq_cycles = {1'b0, timer_q} + (TMR_W + 1)'(1);
    if (state_q == S_REJECT && state_d == S_IDLE) rej_cnt_d = rej_cnt_q + CNT_W'(1);
    if (state_q == S_TORQUE && state_d != S_TORQUE) begin
      last_tq_d = (32'(tq_cycles) > 32'd31) ? 5'd31 : 5'(tq_cycles);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rej_cnt_q <= '0;
      last_tq_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
      last_tq_q <= last_tq_d;
    end
  end

  assign reject_count       = rej_cnt_q;
  assign last_torque_cycles = last_tq_q;
`endif

endmodule
